// File: rtl/speed_input_ctrl.sv
// Button sync/debounce and saturating speed stepper feeding rpm_ctrl.
// Optional auto-repeat on held buttons when AUTO_REPEAT_EN is defined.
module speed_input_ctrl #(
  parameter int DEBOUNCE_MS = 10,
  parameter int MAX_SPEED   = 15,
  parameter int REPEAT_MS   = 300
) (
  input  logic       clk_100mhz,
  input  logic       rst_btn,
  input  logic       tick_1khz,
  input  logic       btn_accel,
  input  logic       btn_decel,
  output logic [3:0] speed_level,
  output logic       accel_pulse,
  output logic       decel_pulse,
  output logic       at_limit
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [3:0] MAXS = 4'(MAX_SPEED);
`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_MS + 1);
`endif

`ifdef AUTO_REPEAT_EN
  typedef enum logic [1:0] {
    ST_IDLE, ST_PRESSED, ST_REPEAT
  } st_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE, ST_PRESSED
  } st_t;
`endif

  logic [1:0] w_raw;
  logic [1:0] w_req;

  assign w_raw = {btn_decel, btn_accel};

  // index 0 is accel, index 1 is decel
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic [1:0]    r_sync;
    logic          r_db;
    logic [CW-1:0] r_cnt;
    st_t           r_st;
    st_t           w_st_nx;
    logic          r_req;
    logic          w_req_nx;
`ifdef AUTO_REPEAT_EN
    logic [RW-1:0] r_rcnt;
    logic [RW-1:0] w_rcnt_nx;
`endif

    always_ff @(posedge clk_100mhz) begin
      if (rst_btn) begin
        r_sync <= '0;
        r_db   <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_sync <= {r_sync[0], w_raw[i]};
        if (tick_1khz) begin
          if (r_sync[1] != r_db) begin
            if (r_cnt == CW'(DEBOUNCE_MS - 1)) begin
              r_db  <= r_sync[1];
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
          end
        end
      end
    end

    always_ff @(posedge clk_100mhz) begin
      if (rst_btn) begin
        r_st  <= ST_IDLE;
        r_req <= 1'b0;
`ifdef AUTO_REPEAT_EN
        r_rcnt <= '0;
`endif
      end else begin
        r_st  <= w_st_nx;
        r_req <= w_req_nx;
`ifdef AUTO_REPEAT_EN
        r_rcnt <= w_rcnt_nx;
`endif
      end
    end

    always_comb begin
      w_st_nx  = r_st;
      w_req_nx = 1'b0;
`ifdef AUTO_REPEAT_EN
      w_rcnt_nx = r_rcnt;
`endif
      unique case (r_st)
        ST_IDLE: begin
          if (r_db) begin
            w_st_nx  = ST_PRESSED;
            w_req_nx = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!r_db) begin
            w_st_nx = ST_IDLE;
          end
`ifdef AUTO_REPEAT_EN
          else if (tick_1khz) begin
            if (r_rcnt == RW'(REPEAT_MS - 1)) begin
              w_st_nx   = ST_REPEAT;
              w_req_nx  = 1'b1;
              w_rcnt_nx = '0;
            end else begin
              w_rcnt_nx = r_rcnt + 1'b1;
            end
          end
        end
        ST_REPEAT: begin
          if (!r_db) begin
            w_st_nx = ST_IDLE;
          end else if (tick_1khz) begin
            if (r_rcnt == RW'(REPEAT_MS - 1)) begin
              w_req_nx  = 1'b1;
              w_rcnt_nx = '0;
            end else begin
              w_rcnt_nx = r_rcnt + 1'b1;
            end
          end
`endif
        end
        default: w_st_nx = ST_IDLE;
      endcase
`ifdef AUTO_REPEAT_EN
      if (w_st_nx == ST_IDLE) begin
        w_rcnt_nx = '0;
      end
`endif
    end

    assign w_req[i] = r_req;
  end

  logic [3:0] w_spd_nx;
  logic       w_accp;
  logic       w_decp;

  // simultaneous requests cancel each other
  always_comb begin
    w_spd_nx = speed_level;
    w_accp   = 1'b0;
    w_decp   = 1'b0;
    if (w_req == 2'b01 && speed_level < MAXS) begin
      w_spd_nx = speed_level + 4'd1;
      w_accp   = 1'b1;
    end else if (w_req == 2'b10 && speed_level != 4'd0) begin
      w_spd_nx = speed_level - 4'd1;
      w_decp   = 1'b1;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst_btn) begin
      speed_level <= 4'd0;
      accel_pulse <= 1'b0;
      decel_pulse <= 1'b0;
      at_limit    <= 1'b1;
    end else begin
      speed_level <= w_spd_nx;
      accel_pulse <= w_accp;
      decel_pulse <= w_decp;
      at_limit    <= (w_spd_nx == 4'd0) || (w_spd_nx == MAXS);
    end
  end

endmodule

// File: tb/tb_speed_input_ctrl.sv
// Directed bench for speed_input_ctrl (default build, no auto-repeat).
// Ticks are compressed to one every 10 clk.
module tb_speed_input_ctrl;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       ba;
  logic       bd;
  logic [3:0] spd;
  logic       ap;
  logic       dp;
  logic       lim;

  int n_tot = 0;
  int n_bad = 0;
  int n_acc = 0;
  int n_dec = 0;
  int cyc   = 0;
  int t0    = 0;
  int lat   = -1;
  int a0;
  int d0;

  speed_input_ctrl dut (
    .clk_100mhz (clk),
    .rst_btn    (rst),
    .tick_1khz  (tick),
    .btn_accel  (ba),
    .btn_decel  (bd),
    .speed_level(spd),
    .accel_pulse(ap),
    .decel_pulse(dp),
    .at_limit   (lim)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ap) n_acc <= n_acc + 1;
    if (dp) n_dec <= n_dec + 1;
    if (ap && lat < 0) lat <= cyc - t0;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // n tick periods with buttons a/d; optional 1-clk bounce mid-period
  task automatic run(input logic a, input logic d, input int n, input bit bnc);
    repeat (n) begin
      for (int k = 0; k < 9; k++) begin
        if (bnc && k == 3) begin
          ba = 1'b0;
          bd = 1'b0;
        end else begin
          ba = a;
          bd = d;
        end
        @(negedge clk);
      end
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic press(input logic a, input logic d);
    run(a, d, 20, 1'b0);
    run(1'b0, 1'b0, 12, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    ba   = 1'b0;
    bd   = 1'b0;
    @(negedge clk);
    do_reset(20);
    chk("rst_spd", spd, 0);
    chk("rst_lim", lim, 1);
    chk("rst_ap", ap, 0);
    chk("rst_dp", dp, 0);

    run(1'b0, 1'b0, 25, 1'b0);
    chk("idle_spd", spd, 0);
    chk("idle_lim", lim, 1);
    chk("idle_pulses", n_acc + n_dec, 0);

    t0 = cyc;
    press(1'b1, 1'b0);
    chk("one_acc", n_acc, 1);
    chk("one_spd", spd, 1);
    chk("one_lim", lim, 0);
    chk("one_lat", lat, 102);

    run(1'b1, 1'b0, 5, 1'b0);
    run(1'b0, 1'b0, 12, 1'b0);
    chk("glitch_acc", n_acc, 1);
    chk("glitch_spd", spd, 1);

    run(1'b1, 1'b0, 20, 1'b1);
    run(1'b0, 1'b0, 12, 1'b0);
    chk("bounce_acc", n_acc, 2);
    chk("bounce_spd", spd, 2);

    do_reset(3);
    chk("rst2_spd", spd, 0);
    a0 = n_acc;
    for (int i = 0; i < 16; i++) press(1'b1, 1'b0);
    chk("sat_hi_spd", spd, 15);
    chk("sat_hi_lim", lim, 1);
    chk("sat_hi_acc", n_acc - a0, 15);
    d0 = n_dec;
    for (int i = 0; i < 16; i++) press(1'b0, 1'b1);
    chk("sat_lo_spd", spd, 0);
    chk("sat_lo_lim", lim, 1);
    chk("sat_lo_dec", n_dec - d0, 15);

    for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
    chk("five_spd", spd, 5);
    chk("five_lim", lim, 0);
    a0 = n_acc;
    d0 = n_dec;
    run(1'b1, 1'b1, 20, 1'b0);
    chk("both_spd", spd, 5);
    chk("both_pulses", (n_acc - a0) + (n_dec - d0), 0);
    run(1'b0, 1'b1, 12, 1'b0);
    run(1'b1, 1'b1, 20, 1'b0);
    run(1'b0, 1'b0, 12, 1'b0);
    chk("held_spd", spd, 6);
    chk("held_acc", n_acc - a0, 1);
    chk("held_dec", n_dec - d0, 0);

    run(1'b1, 1'b0, 7, 1'b0);
    a0 = n_acc;
    do_reset(3);
    chk("mid_rst_spd", spd, 0);
    chk("mid_rst_lim", lim, 1);
    run(1'b1, 1'b0, 9, 1'b0);
    chk("fresh9_spd", spd, 0);
    chk("fresh9_acc", n_acc - a0, 0);
    run(1'b1, 1'b0, 3, 1'b0);
    chk("fresh12_spd", spd, 1);
    chk("fresh12_acc", n_acc - a0, 1);
    run(1'b0, 1'b0, 12, 1'b0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
